beta_decode: RTL and testbench
==============================

# beta_decode

Decode/operand-fetch stage of the Beta pipeline, directly upstream of the ALU. It accepts one 32-bit Beta instruction per handshake and reads operands from the 32×32 register file it owns. It produces, one cycle later and registered, the ALU function code, both ALU operands and the control bits needed by the memory and writeback stages. A pending-write scoreboard stalls issue on RAW and WAW hazards, and a writeback port updates the register file with same-cycle forwarding.

## Interface
Parameters:
- `NREG`, 32: register count (R31 hardwired to zero); fixed, listed for readability.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: instruction.
- `in_pc4` in 32: address of the instruction + 4.
- `flush` in 1: discard the output-register contents.
- `wb_en` in 1: writeback strobe.
- `wb_addr` in 5: writeback register.
- `wb_data` in 32: writeback value.
- `out_valid` out 1: outputs hold a decoded instruction.
- `out_ready` in 1: downstream consumes.
- `alu_fn` out 6: ALU function.
- `alu_a` out 32: ALU first operand.
- `alu_b` out 32: ALU second operand.
- `rc` out 5: destination register.
- `we` out 1: instruction writes `rc`.
- `mem_rd` out 1: load.
- `mem_wr` out 1: store.
- `st_data` out 32: store data, `reg[rc]`.
- `br` out 2: 00 none, 01 JMP, 10 BEQ, 11 BNE.
- `br_ra` out 32: `reg[ra]`, for the branch test.
- `br_target` out 32: branch/jump target.
- `illegal` out 1: unsupported opcode.

## Operation
Instruction fields:
- `op` = `[31:26]`, `rc` = `[25:21]`, `ra` = `[20:16]`, `rb` = `[15:11]`, `lit` = `sext([15:0])`.

Register file:
- Reads are combinational.
- R31 always reads 0; writes to R31 are ignored.
- When `wb_en` is high and `wb_addr` matches a source address, the read returns `wb_data` in the same cycle (forwarding).
- Register contents are not reset.

ALU function codes:
- ADD 0x10, SUB 0x11
- CMPEQ 0x03, CMPLT 0x05, CMPLE 0x07
- AND 0x28, OR 0x2E, XOR 0x26, XNOR 0x29
- SHL 0x30, SHR 0x31, SRA 0x33

Decode by opcode:
- OP 0x20/21/24/25/26/28/29/2A/2B/2C/2D/2E: `alu_a` = `reg[ra]`, `alu_b` = `reg[rb]`, `we` = 1.
- OPC (op + 0x10): same functions, with `alu_b` = `lit`.
- LD 0x18: fn ADD, `alu_a` = `reg[ra]`, `alu_b` = `lit`, `mem_rd` = 1, `we` = 1.
- ST 0x19: fn ADD, `alu_a` = `reg[ra]`, `alu_b` = `lit`, `mem_wr` = 1, `we` = 0, `st_data` = `reg[rc]`.
- JMP 0x1B, BEQ 0x1C, BNE 0x1D: fn ADD, `alu_a` = `in_pc4`, `alu_b` = 0, `we` = 1, `br_ra` = `reg[ra]`.
  - JMP: `br_target` = `reg[ra] & ~3`.
  - BEQ/BNE: `br_target` = `in_pc4 + (lit << 2)`, mod 2^32.
- Any other opcode: `illegal` = 1; `we`, `mem_rd`, `mem_wr` and `br` all 0; fn ADD.
- `we` is forced to 0 when `rc` = 31.

Scoreboard (32-bit `pending`):
- Sources by instruction type:
  - OP: ra, rb.
  - OPC and LD: ra.
  - ST: ra, rc.
  - JMP, BEQ, BNE: ra.
- A source is busy if its `pending` bit is 1 and it is not being cleared by writeback this cycle (`wb_en` with matching `wb_addr`).
- The destination is busy (WAW) if `we` = 1 and `pending[rc]` = 1, with the same writeback exception.
- `in_ready` = (!`out_valid` || `out_ready`) && !`flush` && !(`in_valid` && any busy).
- Accept occurs when `in_valid` && `in_ready`. On accept: the output register loads the decode and `pending[rc]` is set if `we` = 1.
- `wb_en` clears `pending[wb_addr]`. If a set and a clear target the same bit in one cycle, the set wins.
- R31 is never pending.

Output register:
- If `out_valid` && `out_ready` and no accept this cycle, `out_valid` goes to 0.
- `flush` forces `out_valid` to 0 next cycle.
  - If `out_valid` && `we` at the time of the flush, `pending[rc]` is cleared.
  - Writebacks from older instructions are still honoured during a flush.
- Outputs hold steady while `out_valid` && !`out_ready`.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle when there are no hazards and `out_ready` = 1.
- Reset (asynchronous, `rst_n` = 0):
  - `out_valid` = 0 and `pending` = 0.
  - All data/control outputs = 0, including `illegal` = 0 and `br` = 00.
  - `in_ready` follows its combinational equation (1 after reset).
- Reset asserted mid-operation drops the held instruction and all pending bits immediately.
- A writeback lands in the register file at the edge; a same-cycle read sees it through forwarding.

## Test plan
- Hazard-free issue: R1 = 5, R2 = 7 via writeback; issue ADD R3, R1, R2 → next cycle `alu_fn` = 0x10, `alu_a` = 5, `alu_b` = 7, `rc` = 3, `we` = 1, `pending[3]` = 1.
- RAW stall: issue SUB R3 → SHLC R4, R3, 2 is held with `in_ready` = 0. In the cycle `wb_en` = 1, `wb_addr` = 3, `wb_data` = 9, the SHLC is accepted with `alu_a` = 9, `alu_b` = 2, fn 0x30.
- Branch and store:
  - BEQ R0, −1 at `in_pc4` = 0x100 → `br` = 10, `br_target` = 0xFC, `alu_a` = 0x100.
  - ST R5, 8(R6) → `mem_wr` = 1, `we` = 0, `st_data` = `reg[5]`.
- R31 and illegal:
  - ADD R31, R31, R31 → operands 0, `we` = 0, no pending bit set.
  - Opcode 0x00 → `illegal` = 1, `we` = 0.
- Backpressure and flush:
  - Hold `out_ready` = 0 for 3 cycles → outputs stable and `in_ready` = 0.
  - Then `flush` with a held ADD to R7 → `out_valid` = 0 and `pending[7]` = 0.
- Asynchronous reset mid-stream with `pending` = 0x0000_00F0 → all outputs and `pending` clear without waiting for a clock edge.

Source files
------------

// File: rtl/beta_decode.sv
// Beta decode/operand-fetch stage: owns the register file (with writeback forwarding),
// tracks in-flight destinations to stall RAW/WAW hazards, and registers the ALU-side bundle.
module beta_decode #(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc4,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  alu_fn,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  rc,
    output logic        we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] st_data,
    output logic [1:0]  br,
    output logic [31:0] br_ra,
    output logic [31:0] br_target,
    output logic        illegal
);

    localparam logic [5:0] FN_ADD = 6'h10;
    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;

    typedef struct packed {
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rc;
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] st_data;
        logic [1:0]  br;
        logic [31:0] br_ra;
        logic [31:0] br_target;
        logic        illegal;
    } out_t;

    logic [31:0] regs_q [NREG];
    logic [31:0] pending_q, pending_d;
    logic        out_valid_q, out_valid_d;
    out_t        out_q, out_d, dec;

    logic [5:0]  f_op;
    logic [4:0]  f_rc, f_ra, f_rb;
    logic [31:0] lit;
    logic [31:0] ra_val, rb_val, rc_val;
    logic [5:0]  op_fn;
    logic        op_fn_ok, is_op, is_opc;
    logic        use_ra, use_rb, use_rc;
    logic [31:0] wb_clr, pend_eff;
    logic        busy, accept;

    assign f_op = in_instr[31:26];
    assign f_rc = in_instr[25:21];
    assign f_ra = in_instr[20:16];
    assign f_rb = in_instr[15:11];
    assign lit  = {{16{in_instr[15]}}, in_instr[15:0]};

    // A same-cycle writeback is visible to the read that happens in that cycle.
    assign ra_val = (f_ra == 5'd31) ? 32'h0 : (wb_en && wb_addr == f_ra) ? wb_data : regs_q[f_ra];
    assign rb_val = (f_rb == 5'd31) ? 32'h0 : (wb_en && wb_addr == f_rb) ? wb_data : regs_q[f_rb];
    assign rc_val = (f_rc == 5'd31) ? 32'h0 : (wb_en && wb_addr == f_rc) ? wb_data : regs_q[f_rc];

    always_comb begin
        op_fn    = FN_ADD;
        op_fn_ok = 1'b1;
        case (f_op[3:0])
            4'h0:    op_fn = 6'h10;
            4'h1:    op_fn = 6'h11;
            4'h4:    op_fn = 6'h03;
            4'h5:    op_fn = 6'h05;
            4'h6:    op_fn = 6'h07;
            4'h8:    op_fn = 6'h28;
            4'h9:    op_fn = 6'h2E;
            4'hA:    op_fn = 6'h26;
            4'hB:    op_fn = 6'h29;
            4'hC:    op_fn = 6'h30;
            4'hD:    op_fn = 6'h31;
            4'hE:    op_fn = 6'h33;
            default: op_fn_ok = 1'b0;
        endcase
    end

    assign is_op  = (f_op[5:4] == 2'b10) && op_fn_ok;
    assign is_opc = (f_op[5:4] == 2'b11) && op_fn_ok;

    always_comb begin
        dec    = '0;
        dec.fn = FN_ADD;
        dec.rc = f_rc;
        use_ra = 1'b0;
        use_rb = 1'b0;
        use_rc = 1'b0;
        if (is_op || is_opc) begin
            dec.fn = op_fn;
            dec.a  = ra_val;
            dec.b  = is_op ? rb_val : lit;
            dec.we = 1'b1;
            use_ra = 1'b1;
            use_rb = is_op;
        end else begin
            case (f_op)
                OP_LD: begin
                    dec.a      = ra_val;
                    dec.b      = lit;
                    dec.mem_rd = 1'b1;
                    dec.we     = 1'b1;
                    use_ra     = 1'b1;
                end
                OP_ST: begin
                    dec.a       = ra_val;
                    dec.b       = lit;
                    dec.mem_wr  = 1'b1;
                    dec.st_data = rc_val;
                    use_ra      = 1'b1;
                    use_rc      = 1'b1;
                end
                OP_JMP, OP_BEQ, OP_BNE: begin
                    // The ALU computes the link value pc4 + 0 for writeback.
                    dec.a     = in_pc4;
                    dec.we    = 1'b1;
                    dec.br_ra = ra_val;
                    use_ra    = 1'b1;
                    if (f_op == OP_JMP) begin
                        dec.br        = 2'b01;
                        dec.br_target = ra_val & ~32'h3;
                    end else begin
                        dec.br        = (f_op == OP_BEQ) ? 2'b10 : 2'b11;
                        dec.br_target = in_pc4 + (lit << 2);
                    end
                end
                default: dec.illegal = 1'b1;
            endcase
        end
        if (f_rc == 5'd31) begin
            dec.we = 1'b0;
        end
    end

    assign wb_clr   = wb_en ? (32'h1 << wb_addr) : 32'h0;
    assign pend_eff = pending_q & ~wb_clr;
    assign busy     = (use_ra & pend_eff[f_ra]) | (use_rb & pend_eff[f_rb]) |
                      ((use_rc | dec.we) & pend_eff[f_rc]);
    assign in_ready = (!out_valid_q || out_ready) && !flush && !(in_valid && busy);
    assign accept   = in_valid && in_ready;

    always_comb begin
        pending_d = pending_q & ~wb_clr;
        if (flush && out_valid_q && out_q.we) begin
            pending_d[out_q.rc] = 1'b0;
        end
        if (accept && dec.we) begin
            pending_d[f_rc] = 1'b1;
        end
        pending_d[31] = 1'b0;

        out_d       = accept ? dec : out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (flush || (out_valid_q && out_ready)) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // Register contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wb_en && wb_addr != 5'd31) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_fn    = out_q.fn;
    assign alu_a     = out_q.a;
    assign alu_b     = out_q.b;
    assign rc        = out_q.rc;
    assign we        = out_q.we;
    assign mem_rd    = out_q.mem_rd;
    assign mem_wr    = out_q.mem_wr;
    assign st_data   = out_q.st_data;
    assign br        = out_q.br;
    assign br_ra     = out_q.br_ra;
    assign br_target = out_q.br_target;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_beta_decode.sv
// Self-checking bench for beta_decode: directed scenarios followed by randomized traffic
// compared against a behavioural model of decode, register file and scoreboard.
`timescale 1ns/1ps
module tb_beta_decode;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, out_ready = 1'b1;
    logic [31:0] in_instr = '0, in_pc4 = '0, wb_data = '0;
    logic [4:0]  wb_addr = '0;
    logic        in_ready, out_valid, we, mem_rd, mem_wr, illegal;
    logic [5:0]  alu_fn;
    logic [31:0] alu_a, alu_b, st_data, br_ra, br_target;
    logic [4:0]  rc;
    logic [1:0]  br;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rc;
        logic        we;
        logic        rd;
        logic        wr;
        logic [31:0] st;
        logic [1:0]  br;
        logic [31:0] bra;
        logic [31:0] bt;
        logic        ill;
    } exp_t;

    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic        m_ov;
    exp_t        m_out;
    int          fn_tab [16] = '{'h10, 'h11, -1, -1, 'h03, 'h05, 'h07, -1,
                                 'h28, 'h2E, 'h26, 'h29, 'h30, 'h31, 'h33, -1};
    int          op_tab [20] = '{'h20, 'h21, 'h24, 'h25, 'h26, 'h28, 'h2C, 'h2E, 'h30, 'h31,
                                 'h35, 'h3A, 'h3D, 'h18, 'h19, 'h1B, 'h1C, 'h1D, 'h00, 'h2F};

    always #5 clk = ~clk;

    beta_decode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc4(in_pc4), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b), .rc(rc), .we(we),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .st_data(st_data), .br(br), .br_ra(br_ra),
        .br_target(br_target), .illegal(illegal)
    );

    function automatic logic [31:0] enc_op(input logic [5:0] op, input logic [4:0] c,
                                           input logic [4:0] a, input logic [4:0] b);
        return {op, c, a, b, 11'd0};
    endfunction

    function automatic logic [31:0] enc_lit(input logic [5:0] op, input logic [4:0] c,
                                            input logic [4:0] a, input logic [15:0] l);
        return {op, c, a, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    // Model register read, including the same-cycle writeback currently driven.
    function automatic logic [31:0] m_rd(input logic [4:0] r);
        if (r == 5'd31) return 32'h0;
        if (wb_en && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic void m_decode(input logic [31:0] ins, input logic [31:0] pc,
                                     output exp_t e, output logic [31:0] need);
        logic [5:0]  op = ins[31:26];
        logic [4:0]  rcf = ins[25:21];
        logic [4:0]  raf = ins[20:16];
        logic [4:0]  rbf = ins[15:11];
        logic [31:0] l = {{16{ins[15]}}, ins[15:0]};
        int          fn;
        e = '0; e.fn = 6'h10; e.rc = rcf; need = '0;
        fn = op[5] ? fn_tab[op[3:0]] : -1;
        if (fn >= 0) begin
            e.fn = 6'(fn); e.a = m_rd(raf); e.we = 1'b1; need[raf] = 1'b1;
            if (op[4]) e.b = l;
            else begin e.b = m_rd(rbf); need[rbf] = 1'b1; end
        end else if (op == 6'h18 || op == 6'h19) begin
            e.a = m_rd(raf); e.b = l; need[raf] = 1'b1;
            if (op == 6'h18) begin e.rd = 1'b1; e.we = 1'b1; end
            else begin e.wr = 1'b1; e.st = m_rd(rcf); need[rcf] = 1'b1; end
        end else if (op >= 6'h1B && op <= 6'h1D) begin
            e.a = pc; e.we = 1'b1; e.bra = m_rd(raf); need[raf] = 1'b1;
            e.br = 2'(op - 6'h1A);
            e.bt = (op == 6'h1B) ? (e.bra & ~32'h3) : pc + l * 4;
        end else begin
            e.ill = 1'b1;
        end
        if (rcf == 5'd31) e.we = 1'b0;
        if (e.we) need[rcf] = 1'b1;
        need[31] = 1'b0;
    endfunction

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] op = 6'(op_tab[$urandom_range(0, 19)]);
        return {op, rand_reg(), rand_reg(), rand_reg(), 11'($urandom)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if ({alu_fn, alu_a, alu_b, rc, we, mem_rd, mem_wr, st_data, br, br_ra, br_target, illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got fn=%h a=%h b=%h rc=%0d we=%b br=%b ill=%b want all 0",
                     alu_fn, alu_a, alu_b, rc, we, br, illegal);
        end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (dut.pending_q !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", dut.pending_q); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_hazard_free();
        wb(5'd1, 32'd5); wb(5'd2, 32'd7); wb(5'd5, 32'hDEADBEEF); wb(5'd6, 32'h40); wb(5'd0, 32'h11);
        in_valid = 1'b1; in_instr = enc_op(6'h20, 5'd3, 5'd1, 5'd2);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        $display("txn ADD R3,R1,R2: fn=%h a=%0d b=%0d rc=%0d we=%b", alu_fn, alu_a, alu_b, rc, we);
        n_checks++;
        if ({out_valid, alu_fn, alu_a, alu_b, rc, we} !== {1'b1, 6'h10, 32'd5, 32'd7, 5'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL add_outputs: got v=%b fn=%h a=%0d b=%0d rc=%0d we=%b want v=1 fn=10 a=5 b=7 rc=3 we=1",
                     out_valid, alu_fn, alu_a, alu_b, rc, we);
        end
        n_checks++; if (dut.pending_q[3] !== 1'b1) begin n_fail++; $display("FAIL add_pending3: got %b want 1", dut.pending_q[3]); end
        tick();
    endtask

    task automatic test_raw_stall();
        wb(5'd3, 32'd12);
        in_valid = 1'b1; in_instr = enc_op(6'h21, 5'd3, 5'd1, 5'd2);
        tick();
        in_instr = enc_lit(6'h3C, 5'd4, 5'd3, 16'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ready[%0d]: got %b want 0", i, in_ready); end
            if (i == 0) begin
                $display("txn SUB R3,R1,R2: fn=%h a=%0d b=%0d", alu_fn, alu_a, alu_b);
                n_checks++;
                if ({out_valid, alu_fn} !== {1'b1, 6'h11}) begin
                    n_fail++; $display("FAIL sub_outputs: got v=%b fn=%h want v=1 fn=11", out_valid, alu_fn);
                end
            end
            tick();
        end
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd9;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release_ready: got %b want 1", in_ready); end
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        $display("txn SHLC R4,R3,2: fn=%h a=%0d b=%0d", alu_fn, alu_a, alu_b);
        n_checks++;
        if ({out_valid, alu_fn, alu_a, alu_b, rc} !== {1'b1, 6'h30, 32'd9, 32'd2, 5'd4}) begin
            n_fail++;
            $display("FAIL shlc_outputs: got v=%b fn=%h a=%0d b=%0d rc=%0d want v=1 fn=30 a=9 b=2 rc=4",
                     out_valid, alu_fn, alu_a, alu_b, rc);
        end
        n_checks++;
        if (dut.pending_q[4:3] !== 2'b10) begin n_fail++; $display("FAIL shlc_pending: got %b want 10", dut.pending_q[4:3]); end
        tick();
    endtask

    task automatic test_branch_store();
        in_valid = 1'b1; in_pc4 = 32'h100; in_instr = enc_lit(6'h1C, 5'd31, 5'd0, 16'hFFFF);
        tick();
        in_instr = enc_lit(6'h19, 5'd5, 5'd6, 16'd8);
        @(negedge clk);
        $display("txn BEQ R0,-1: br=%b target=%h a=%h", br, br_target, alu_a);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        n_checks++;
        if ({br, br_target, alu_a, alu_b, br_ra, we} !== {2'b10, 32'hFC, 32'h100, 32'h0, 32'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL beq_outputs: got br=%b tgt=%h a=%h b=%h bra=%h we=%b want br=10 tgt=fc a=100 b=0 bra=11 we=0",
                     br, br_target, alu_a, alu_b, br_ra, we);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        $display("txn ST R5,8(R6): wr=%b st_data=%h a=%h b=%h", mem_wr, st_data, alu_a, alu_b);
        n_checks++;
        if ({mem_wr, mem_rd, we, st_data, alu_a, alu_b, br} !== {3'b100, 32'hDEADBEEF, 32'h40, 32'd8, 2'b00}) begin
            n_fail++;
            $display("FAIL st_outputs: got wr=%b rd=%b we=%b st=%h a=%h b=%h br=%b want wr=1 rd=0 we=0 st=deadbeef a=40 b=8 br=00",
                     mem_wr, mem_rd, we, st_data, alu_a, alu_b, br);
        end
        tick();
    endtask

    task automatic test_r31_illegal();
        in_valid = 1'b1; in_instr = enc_op(6'h20, 5'd31, 5'd31, 5'd31);
        tick();
        in_instr = 32'h0;
        @(negedge clk);
        $display("txn ADD R31,R31,R31: a=%h b=%h we=%b", alu_a, alu_b, we);
        n_checks++;
        if ({alu_a, alu_b, we} !== 65'h0) begin
            n_fail++; $display("FAIL r31_outputs: got a=%h b=%h we=%b want 0 0 0", alu_a, alu_b, we);
        end
        n_checks++; if (dut.pending_q !== 32'h10) begin n_fail++; $display("FAIL r31_pending: got %h want 00000010", dut.pending_q); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        $display("txn opcode 00: illegal=%b we=%b", illegal, we);
        n_checks++;
        if ({illegal, we, br, mem_rd, mem_wr, alu_fn} !== {1'b1, 1'b0, 2'b00, 2'b00, 6'h10}) begin
            n_fail++;
            $display("FAIL illegal_outputs: got ill=%b we=%b br=%b rd=%b wr=%b fn=%h want ill=1 we=0 br=00 rd=0 wr=0 fn=10",
                     illegal, we, br, mem_rd, mem_wr, alu_fn);
        end
        tick();
    endtask

    task automatic test_backpressure_flush();
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h0;
        in_valid = 1'b1; in_instr = enc_op(6'h20, 5'd7, 5'd1, 5'd2);
        tick();
        wb_en = 1'b0; out_ready = 1'b0; in_instr = enc_op(6'h20, 5'd8, 5'd1, 5'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_valid, rc, alu_a, alu_b} !== {1'b0, 1'b1, 5'd7, 32'd5, 32'd7}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got rdy=%b v=%b rc=%0d a=%0d b=%0d want rdy=0 v=1 rc=7 a=5 b=7",
                         i, in_ready, out_valid, rc, alu_a, alu_b);
            end
            tick();
        end
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        $display("txn flush of ADD R7: out_valid=%b pending=%h", out_valid, dut.pending_q);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_checks++; if (dut.pending_q !== 32'h0) begin n_fail++; $display("FAIL flush_pending: got %h want 0", dut.pending_q); end
        tick();
    endtask

    task automatic test_random();
        exp_t        e;
        logic [31:0] need, clr, np;
        logic        exp_ready, acc;
        for (int r = 0; r < 31; r++) begin
            m_regs[r] = $urandom;
            wb(5'(r), m_regs[r]);
        end
        m_regs[31] = 32'h0; m_pend = '0; m_ov = 1'b0; m_out = '0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc4    = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_addr   = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            @(negedge clk);
            n_checks++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", i, out_valid, m_ov); end
            n_checks++; if (dut.pending_q !== m_pend) begin n_fail++; $display("FAIL rnd_pending[%0d]: got %h want %h", i, dut.pending_q, m_pend); end
            if (m_ov) begin
                n_checks++;
                if ({alu_fn, rc, we, mem_rd, mem_wr, br, illegal} !== {m_out.fn, m_out.rc, m_out.we, m_out.rd, m_out.wr, m_out.br, m_out.ill}) begin
                    n_fail++;
                    $display("FAIL rnd_ctrl[%0d]: got fn=%h rc=%0d we=%b rd=%b wr=%b br=%b ill=%b want fn=%h rc=%0d we=%b rd=%b wr=%b br=%b ill=%b",
                             i, alu_fn, rc, we, mem_rd, mem_wr, br, illegal,
                             m_out.fn, m_out.rc, m_out.we, m_out.rd, m_out.wr, m_out.br, m_out.ill);
                end
                if (!m_out.ill) begin
                    n_checks++;
                    if ({alu_a, alu_b} !== {m_out.a, m_out.b}) begin
                        n_fail++; $display("FAIL rnd_operands[%0d]: got a=%h b=%h want a=%h b=%h", i, alu_a, alu_b, m_out.a, m_out.b);
                    end
                end
                if (m_out.wr) begin
                    n_checks++;
                    if (st_data !== m_out.st) begin n_fail++; $display("FAIL rnd_st_data[%0d]: got %h want %h", i, st_data, m_out.st); end
                end
                if (m_out.br != 2'b00) begin
                    n_checks++;
                    if ({br_ra, br_target} !== {m_out.bra, m_out.bt}) begin
                        n_fail++; $display("FAIL rnd_branch[%0d]: got ra=%h tgt=%h want ra=%h tgt=%h", i, br_ra, br_target, m_out.bra, m_out.bt);
                    end
                end
            end
            m_decode(in_instr, in_pc4, e, need);
            clr = wb_en ? (32'h1 << wb_addr) : 32'h0;
            exp_ready = (!m_ov || out_ready) && !flush && !(in_valid && ((need & m_pend & ~clr) != 0));
            n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, in_ready, exp_ready); end
            acc = in_valid && exp_ready;
            if (acc) $display("txn rnd %0d: instr=%h pc4=%h", i, in_instr, in_pc4);
            np = m_pend & ~clr;
            if (flush && m_ov && m_out.we) np[m_out.rc] = 1'b0;
            if (acc && e.we) np[e.rc] = 1'b1;
            np[31] = 1'b0;
            if (acc) begin m_ov = 1'b1; m_out = e; end
            else if (flush || (m_ov && out_ready)) m_ov = 1'b0;
            if (wb_en && wb_addr != 5'd31) m_regs[wb_addr] = wb_data;
            m_pend = np;
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 4; r < 8; r++) begin
            in_valid = 1'b1; in_instr = enc_op(6'h20, 5'(r), 5'd0, 5'd0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (dut.pending_q !== 32'hF0) begin n_fail++; $display("FAIL pre_reset_pending: got %h want 000000f0", dut.pending_q); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        $display("txn async reset: out_valid=%b pending=%h", out_valid, dut.pending_q);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (dut.pending_q !== 32'h0) begin n_fail++; $display("FAIL areset_pending: got %h want 0", dut.pending_q); end
        n_checks++;
        if ({alu_fn, alu_a, alu_b, rc, we, mem_rd, mem_wr, st_data, br, br_ra, br_target, illegal} !== '0) begin
            n_fail++;
            $display("FAIL areset_outputs: got fn=%h a=%h b=%h rc=%0d we=%b br=%b want all 0", alu_fn, alu_a, alu_b, rc, we, br);
        end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_hazard_free();
        test_raw_stall();
        test_branch_store();
        test_r31_illegal();
        test_backpressure_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
